string_sequencer: RTL

Sequencer that feeds the POV character path. It latches a packed 7-slot message into the `String` register and pulses `CompareString` so the downstream null-string check samples a stable value. It then steps through the slots and presents each valid character on `DataChar` for control to render, one character per `NextChar` request. It sits between the message source and control/comparer: it produces the `String`, `CompareString` and `DataChar` signals that the comparer consumes.

---
 rtl/string_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/string_sequencer.sv
// string_sequencer: latches a packed multi-slot message, strobes CompareString
// while the latched copy is stable, then presents each valid slot's character
// code one at a time, advancing on every NextChar request.
module string_sequencer #(
    parameter int NCHARS = 7,
    parameter int CHARW  = 10,
    parameter int SLOTW  = CHARW + 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    LoadString,
    input  logic [0:NCHARS*SLOTW-1] StringIn,
    input  logic                    NextChar,
    output logic [0:NCHARS*SLOTW-1] String,
    output logic                    CompareString,
    output logic [0:CHARW-1]        DataChar,
    output logic                    CharValid,
    output logic [2:0]              CharIndex,
    output logic                    Done
);

    localparam int         STRW  = NCHARS * SLOTW;
    localparam int         BASEW = $clog2(STRW);
    localparam logic [2:0] LAST  = 3'(NCHARS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SCAN,
        PRESENT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [0:STRW-1]   string_next;
    logic [0:CHARW-1]  data_next;
    logic              valid_next;
    logic              compare_next;
    logic              done_next;
    logic [2:0]        index_next;

    logic [BASEW-1:0]  slot_base;
    logic [BASEW-1:0]  code_base;
    logic              slot_valid;
    logic [0:CHARW-1]  slot_code;

    // Pick out the flag and code of the slot currently addressed by CharIndex.
    // The flag is the lowest-numbered bit of the slot, the code follows MSB first.
    always_comb begin
        slot_base  = BASEW'(CharIndex) * BASEW'(SLOTW);
        code_base  = slot_base + BASEW'(1);
        slot_valid = String[slot_base];
        slot_code  = String[code_base +: CHARW];
    end

    // Next-state and next-output logic; a load request overrides every state,
    // including a pending NextChar, so a new message always restarts cleanly.
    always_comb begin
        state_next   = state;
        string_next  = String;
        data_next    = DataChar;
        valid_next   = CharValid;
        index_next   = CharIndex;
        compare_next = 1'b0;
        done_next    = 1'b0;

        if (LoadString) begin
            string_next  = StringIn;
            index_next   = 3'd0;
            valid_next   = 1'b0;
            data_next    = '0;
            compare_next = 1'b1;
            state_next   = CHECK;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                CHECK: begin
                    // Only an all-zero message counts as empty; stray code bits
                    // with clear flags still go through a full scan.
                    if (String == '0) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = SCAN;
                    end
                end
                SCAN: begin
                    if (slot_valid) begin
                        data_next  = slot_code;
                        valid_next = 1'b1;
                        state_next = PRESENT;
                    end else if (CharIndex < LAST) begin
                        index_next = CharIndex + 3'd1;
                    end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end
                end
                PRESENT: begin
                    if (NextChar) begin
                        valid_next = 1'b0;
                        data_next  = '0;
                        if (CharIndex == LAST) begin
                            state_next = DONE;
                            done_next  = 1'b1;
                        end else begin
                            index_next = CharIndex + 3'd1;
                            state_next = SCAN;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register and registered outputs; reset returns everything to zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            String        <= '0;
            DataChar      <= '0;
            CharValid     <= 1'b0;
            CharIndex     <= 3'd0;
            CompareString <= 1'b0;
            Done          <= 1'b0;
        end else begin
            state         <= state_next;
            String        <= string_next;
            DataChar      <= data_next;
            CharValid     <= valid_next;
            CharIndex     <= index_next;
            CompareString <= compare_next;
            Done          <= done_next;
        end
    end

endmodule
